// File: rtl/router_pkg.sv
// Shared router definitions: allocator state encoding and default port/credit sizing.
package router_pkg;
  typedef enum logic {OPA_IDLE = 1'b0, OPA_LOCKED = 1'b1} opa_state_e;

  localparam int NR_PORTS    = 5;
  localparam int DEF_CREDITS = 4;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester at index >= ptr, else lowest requester (wrap-around).
module rr_pick
  import router_pkg::*;
#(
  parameter int NR = NR_PORTS,
  parameter int PW = $clog2(NR)
) (
  input  logic [NR-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NR-1:0] gnt,
  output logic [PW-1:0] idx
);
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = PW'(i);
        found  = 1'b1;
      end
    end
    // Nothing at or above the pointer: wrap to the lowest requester.
    for (int i = 0; i < NR; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        idx    = PW'(i);
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/out_port_alloc.sv
// Per-output-port wormhole allocator with round-robin arbitration and credit gating.
// Optional build macro OPA_CREDIT_CHK_EN adds the sticky CREDIT_ERR flag.
module out_port_alloc
  import router_pkg::*;
#(
  parameter int NR      = NR_PORTS,
  parameter int CREDITS = DEF_CREDITS,
  parameter int PW      = $clog2(NR),
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [NR-1:0] REQ,
  input  logic [NR-1:0] TAIL,
  input  logic          CREDIT_IN,
  output logic [NR-1:0] GRT,
  output logic          VLD_OUT,
  output logic          LOCKED,
  output logic [CW-1:0] CREDIT_CNT
`ifdef OPA_CREDIT_CHK_EN
  ,
  output logic          CREDIT_ERR
`endif
);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [PW-1:0] PTR_LAST = PW'(NR - 1);

  opa_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0] cred_q, cred_d;
  logic [NR-1:0] pick_gnt, owner_oh;
  logic [PW-1:0] pick_idx;
  logic          cred_ok, grant, grant_tail;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Simultaneous grant and return cancel; returns beyond full depth are dropped.
  function automatic logic [CW-1:0] cred_update(input logic [CW-1:0] c,
                                                input logic dec, input logic inc);
    logic [CW-1:0] r;
    r = c;
    if (dec && !inc)
      r = c - 1'b1;
    else if (inc && !dec && (c != CRED_MAX))
      r = c + 1'b1;
    return r;
  endfunction

  rr_pick #(.NR(NR), .PW(PW)) u_pick (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign owner_oh   = NR'(1) << owner_q;
  assign cred_ok    = (cred_q != '0);
  assign grant      = |GRT;
  assign grant_tail = |(GRT & TAIL);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= OPA_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cred_q  <= CRED_MAX;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cred_q  <= cred_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      OPA_IDLE: begin
        if (grant) begin
          if (grant_tail) begin
            ptr_d = ptr_after(pick_idx);
          end else begin
            state_d = OPA_LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      OPA_LOCKED: begin
        if (grant && grant_tail) begin
          state_d = OPA_IDLE;
          ptr_d   = ptr_after(owner_q);
        end
      end
      default: state_d = OPA_IDLE;
    endcase
    cred_d = cred_update(cred_q, grant, CREDIT_IN);
  end

  // Zero-cycle grant: the crossbar select is driven straight from this decode.
  always_comb begin
    GRT = '0;
    if (cred_ok) begin
      if (state_q == OPA_IDLE)
        GRT = pick_gnt;
      else if (REQ[owner_q])
        GRT = owner_oh;
    end
  end

  assign VLD_OUT    = grant;
  assign LOCKED     = (state_q == OPA_LOCKED);
  assign CREDIT_CNT = cred_q;

`ifdef OPA_CREDIT_CHK_EN
  logic err_q, overflow, bad_tail;

  assign overflow = CREDIT_IN && !grant && (cred_q == CRED_MAX);
  assign bad_tail = (state_q == OPA_LOCKED) && REQ[owner_q] && (|(GRT & TAIL & ~owner_oh));

  always_ff @(posedge CLK) begin
    if (!RSTn)
      err_q <= 1'b0;
    else if (overflow || bad_tail)
      err_q <= 1'b1;
  end

  assign CREDIT_ERR = err_q;
`endif
endmodule

// File: tb/tb_out_port_alloc.sv
// Bench for out_port_alloc: directed vector table, hand sequences, randomized model comparison.
module tb_out_port_alloc;
  localparam int NR      = 5;
  localparam int CREDITS = 4;
  localparam int CW      = 3;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [NR-1:0] REQ, TAIL, GRT;
  logic          CREDIT_IN, VLD_OUT, LOCKED;
  logic [CW-1:0] CREDIT_CNT;
`ifdef OPA_CREDIT_CHK_EN
  logic          CREDIT_ERR;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  out_port_alloc #(.NR(NR), .CREDITS(CREDITS)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .REQ        (REQ),
    .TAIL       (TAIL),
    .CREDIT_IN  (CREDIT_IN),
    .GRT        (GRT),
    .VLD_OUT    (VLD_OUT),
    .LOCKED     (LOCKED),
    .CREDIT_CNT (CREDIT_CNT)
`ifdef OPA_CREDIT_CHK_EN
    ,
    .CREDIT_ERR (CREDIT_ERR)
`endif
  );

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] tail;
    logic          cin;
    logic [NR-1:0] grt;
    logic          lk;
    int            cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [NR-1:0] q, input logic [NR-1:0] t, input logic c,
                             input logic [NR-1:0] g, input logic lk, input int cnt);
    vec_t r;
    r.req = q; r.tail = t; r.cin = c; r.grt = g; r.lk = lk; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [NR-1:0] q, input logic [NR-1:0] t,
                       input logic c);
    @(negedge CLK);
    RSTn = r; REQ = q; TAIL = t; CREDIT_IN = c;
    #1;
  endtask

  // Reference model: port state kept as plain integers.
  int m_locked, m_owner, m_ptr, m_cred, m_err;

  function automatic logic [NR-1:0] model_grt(input logic [NR-1:0] q);
    logic [NR-1:0] g;
    g = '0;
    if (m_cred == 0) return g;
    if (m_locked != 0) begin
      if (q[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_ptr + k) % NR;
      if (q[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_step(input logic r, input logic [NR-1:0] q, input logic [NR-1:0] t,
                            input logic c);
    logic [NR-1:0] g;
    int w;
    if (!r) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = CREDITS; m_err = 0;
      return;
    end
    g = model_grt(q);
    w = -1;
    for (int i = 0; i < NR; i++) if (g[i]) w = i;
    if (c && (w < 0) && (m_cred == CREDITS)) m_err = 1;
    if (w >= 0) begin
      if (t[w]) begin
        m_locked = 0;
        m_ptr    = (w + 1) % NR;
      end else begin
        m_locked = 1;
        m_owner  = w;
      end
    end
    m_cred = m_cred - ((w >= 0) ? 1 : 0) + (c ? 1 : 0);
    if (m_cred > CREDITS) m_cred = CREDITS;
  endtask

  initial begin
    RSTn = 1'b0; REQ = '0; TAIL = '0; CREDIT_IN = 1'b0;

    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, 1'b0);
    check("reset_grt", 32'(GRT), 32'h0);
    check("reset_vld", 32'(VLD_OUT), 32'h0);
    check("reset_locked", 32'(LOCKED), 32'h0);
    check("reset_cnt", 32'(CREDIT_CNT), CREDITS);

    // Single-flit round robin, then wormhole lock, bubble, credit stall, cancel, wrap, saturate.
    tbl.push_back(v(5'b10100, 5'b11111, 1, 5'b00100, 0, 4));
    tbl.push_back(v(5'b10100, 5'b11111, 1, 5'b10000, 0, 4));
    tbl.push_back(v(5'b10100, 5'b11111, 1, 5'b00100, 0, 4));
    tbl.push_back(v(5'b01000, 5'b11111, 1, 5'b01000, 0, 4));
    tbl.push_back(v(5'b01010, 5'b00000, 1, 5'b00010, 0, 4));
    tbl.push_back(v(5'b01010, 5'b00000, 1, 5'b00010, 1, 4));
    tbl.push_back(v(5'b01010, 5'b00000, 1, 5'b00010, 1, 4));
    tbl.push_back(v(5'b01010, 5'b00010, 1, 5'b00010, 1, 4));
    tbl.push_back(v(5'b01000, 5'b01000, 1, 5'b01000, 0, 4));
    tbl.push_back(v(5'b00001, 5'b00000, 1, 5'b00001, 0, 4));
    tbl.push_back(v(5'b11110, 5'b11110, 1, 5'b00000, 1, 4));
    tbl.push_back(v(5'b00001, 5'b00001, 1, 5'b00001, 1, 4));
    tbl.push_back(v(5'b00001, 5'b00000, 0, 5'b00001, 0, 4));
    tbl.push_back(v(5'b00001, 5'b00000, 0, 5'b00001, 1, 3));
    tbl.push_back(v(5'b00001, 5'b00000, 0, 5'b00001, 1, 2));
    tbl.push_back(v(5'b00001, 5'b00000, 0, 5'b00001, 1, 1));
    tbl.push_back(v(5'b00001, 5'b00000, 0, 5'b00000, 1, 0));
    tbl.push_back(v(5'b00001, 5'b00000, 0, 5'b00000, 1, 0));
    tbl.push_back(v(5'b00001, 5'b00000, 1, 5'b00000, 1, 0));
    tbl.push_back(v(5'b00001, 5'b00001, 0, 5'b00001, 1, 1));
    tbl.push_back(v(5'b00001, 5'b00001, 0, 5'b00000, 0, 0));
    tbl.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 0));
    tbl.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 1));
    tbl.push_back(v(5'b00100, 5'b00100, 1, 5'b00100, 0, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 0, 5'b00000, 0, 2));
    tbl.push_back(v(5'b01000, 5'b11111, 1, 5'b01000, 0, 2));
    tbl.push_back(v(5'b10001, 5'b11111, 1, 5'b10000, 0, 2));
    tbl.push_back(v(5'b10001, 5'b11111, 1, 5'b00001, 0, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 2));
    tbl.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 3));
    tbl.push_back(v(5'b00000, 5'b00000, 1, 5'b00000, 0, 4));
    tbl.push_back(v(5'b00000, 5'b00000, 0, 5'b00000, 0, 4));

    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].req, tbl[i].tail, tbl[i].cin);
      check($sformatf("vec%0d_grt", i), 32'(GRT), 32'(tbl[i].grt));
      check($sformatf("vec%0d_vld", i), 32'(VLD_OUT), 32'(|tbl[i].grt));
      check($sformatf("vec%0d_locked", i), 32'(LOCKED), 32'(tbl[i].lk));
      check($sformatf("vec%0d_cnt", i), 32'(CREDIT_CNT), 32'(tbl[i].cnt));
    end

    // Reset in the middle of a locked packet with one credit left.
    drive(1'b1, 5'b00010, 5'b00000, 1'b0);
    check("t6_head_grt", 32'(GRT), 32'b00010);
    drive(1'b1, 5'b00010, 5'b00000, 1'b0);
    drive(1'b1, 5'b00010, 5'b00000, 1'b0);
    drive(1'b0, 5'b00010, 5'b00000, 1'b0);
    check("t6_pre_locked", 32'(LOCKED), 32'h1);
    check("t6_pre_cnt", 32'(CREDIT_CNT), 32'd1);
    drive(1'b1, 5'b00000, 5'b00000, 1'b0);
    check("t6_post_locked", 32'(LOCKED), 32'h0);
    check("t6_post_cnt", 32'(CREDIT_CNT), CREDITS);
    check("t6_post_grt", 32'(GRT), 32'h0);
`ifdef OPA_CREDIT_CHK_EN
    check("t6_err_clear", 32'(CREDIT_ERR), 32'h0);
    drive(1'b1, 5'b00000, 5'b00000, 1'b1);
    drive(1'b1, 5'b00000, 5'b00000, 1'b0);
    check("t6_err_set", 32'(CREDIT_ERR), 32'h1);
    check("t6_err_cnt", 32'(CREDIT_CNT), CREDITS);
`endif

    // Randomized traffic against the reference model.
    drive(1'b0, '0, '0, 1'b0);
    model_step(1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      logic          r, c;
      logic [NR-1:0] q, t, eg;
      r = ($urandom_range(0, 59) != 0);
      q = NR'($urandom);
      for (int b = 0; b < NR; b++) t[b] = ($urandom_range(0, 9) < 4);
      c = ($urandom_range(0, 1) == 1);
      drive(r, q, t, c);
      eg = model_grt(q);
      check("rnd_grt", 32'(GRT), 32'(eg));
      check("rnd_vld", 32'(VLD_OUT), 32'(|eg));
      check("rnd_locked", 32'(LOCKED), 32'(m_locked));
      check("rnd_cnt", 32'(CREDIT_CNT), 32'(m_cred));
`ifdef OPA_CREDIT_CHK_EN
      check("rnd_err", 32'(CREDIT_ERR), 32'(m_err));
`endif
      model_step(r, q, t, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
